i2s_rx: RTL and testbench

//  I2S receiver (slave): the receive-side counterpart of the i2s transmitter.

---
 rtl/i2s_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2s_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises bclk/lrclk/data into clk, deserialises stereo
// frames into a FIFO read by the mp over the EVB responder, with a fill-level irq.
module i2s_rx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_i2s_bclk,
  input  logic        io_i2s_lrclk,
  input  logic        io_i2s_data,
  input  logic        evb_cmd_request,
  input  logic [3:0]  evb_cmd_addr,
  input  logic [1:0]  evb_cmd_wr_mask,
  input  logic [31:0] evb_cmd_wr_data,
  output logic        evb_cmd_finish,
  output logic [31:0] evb_cmd_rd_data,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} evb_state_t;

  function automatic logic [15:0] sext(input logic [SAMPLE_W-1:0] w);
    logic [15:0] t;
    t = 16'(w) << (16 - SAMPLE_W);
    return 16'($signed(t) >>> (16 - SAMPLE_W));
  endfunction

  logic [2:0]          bclk_sync_r;
  logic [1:0]          ws_sync_r;
  logic [1:0]          data_sync_r;
  logic                ws_q_r;
  logic                armed_r;
  logic                msb_pend_r;
  logic                chan_r;
  logic [SAMPLE_W-1:0] shreg_r;
  logic [4:0]          bitcnt_r;
  logic                left_vld_r;
  logic [15:0]         left_r;
  logic                push_r;
  logic [31:0]         push_data_r;

  logic                en_r;
  logic [4:0]          thr_r;
  logic                ovf_r;
  logic                udf_r;
  logic [15:0]         frames_r;
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic [31:0]         mem_r [FIFO_DEPTH];
  evb_state_t          evb_state_r;

  logic                bclk_rise_s;
  logic                ws_s;
  logic [4:0]          cnt_base_s;
  logic                shift_s;
  logic                done_s;
  logic                chan_s;
  logic [SAMPLE_W-1:0] word_s;
  logic                empty_s;
  logic                full_s;
  logic                push_ok_s;
  logic                ovf_set_s;
  logic [31:0]         status_s;
  logic [31:0]         rd_val_s;
  logic                pop_s;
  logic                udf_set_s;
  logic                flush_s;
  logic                ctrl_wr_s;
  logic                w1c_s;

  // Bit-engine and FIFO status decode
  always_comb begin
    bclk_rise_s = bclk_sync_r[1] & ~bclk_sync_r[2];
    ws_s        = ws_sync_r[1];
    cnt_base_s  = msb_pend_r ? 5'd0 : bitcnt_r;
    shift_s     = en_r & armed_r & bclk_rise_s & (cnt_base_s < 5'(SAMPLE_W));
    done_s      = shift_s & ((cnt_base_s + 5'd1) == 5'(SAMPLE_W));
    chan_s      = msb_pend_r ? ws_s : chan_r;
    word_s      = {shreg_r[SAMPLE_W-2:0], data_sync_r[1]};
    empty_s     = (count_r == '0);
    full_s      = (count_r == CW'(FIFO_DEPTH));
    push_ok_s   = push_r & ~full_s & ~flush_s;
    ovf_set_s   = push_r & full_s & ~flush_s;
    status_s         = 32'd0;
    status_s[CW-1:0] = count_r;
    status_s[8]      = empty_s;
    status_s[9]      = full_s;
    status_s[16]     = ovf_r;
    status_s[17]     = udf_r;
  end

  // EVB register decode for the accepting cycle
  always_comb begin
    rd_val_s  = 32'd0;
    pop_s     = 1'b0;
    udf_set_s = 1'b0;
    flush_s   = 1'b0;
    ctrl_wr_s = 1'b0;
    w1c_s     = 1'b0;
    if ((evb_state_r == ST_IDLE) && evb_cmd_request) begin
      case (evb_cmd_addr)
        4'h0: begin
          rd_val_s  = {19'd0, thr_r, 6'd0, 1'b0, en_r};
          ctrl_wr_s = evb_cmd_wr_mask[0];
          flush_s   = evb_cmd_wr_mask[0] & evb_cmd_wr_data[1];
        end
        4'h1: begin
          rd_val_s = status_s;
          w1c_s    = evb_cmd_wr_mask[1];
        end
        4'h2: begin
          if (evb_cmd_wr_mask != 2'b00) begin
            rd_val_s = 32'd0;
          end else if (empty_s) begin
            udf_set_s = 1'b1;
          end else begin
            pop_s    = 1'b1;
            rd_val_s = mem_r[rd_ptr_r];
          end
        end
        4'h3:    rd_val_s = {16'd0, frames_r};
        default: rd_val_s = 32'd0;
      endcase
    end else begin
      rd_val_s = 32'd0;
    end
  end

  // Input synchronisers and serial bit engine
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_r <= 3'd0;
      ws_sync_r   <= 2'd0;
      data_sync_r <= 2'd0;
      ws_q_r      <= 1'b0;
      armed_r     <= 1'b0;
      msb_pend_r  <= 1'b0;
      chan_r      <= 1'b0;
      shreg_r     <= '0;
      bitcnt_r    <= 5'd0;
      left_vld_r  <= 1'b0;
      left_r      <= 16'd0;
      push_r      <= 1'b0;
      push_data_r <= 32'd0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[1:0], io_i2s_bclk};
      ws_sync_r   <= {ws_sync_r[0], io_i2s_lrclk};
      data_sync_r <= {data_sync_r[0], io_i2s_data};
      push_r      <= 1'b0;
      // ws_q keeps tracking while disabled so re-enable waits for a genuine edge
      if (bclk_rise_s) ws_q_r <= ws_s;
      if (!en_r) begin
        armed_r    <= 1'b0;
        msb_pend_r <= 1'b0;
        shreg_r    <= '0;
        bitcnt_r   <= 5'd0;
        left_vld_r <= 1'b0;
      end else if (bclk_rise_s) begin
        if (ws_s != ws_q_r) begin
          armed_r    <= 1'b1;
          msb_pend_r <= 1'b1;
        end else begin
          msb_pend_r <= 1'b0;
        end
        chan_r <= chan_s;
        if (shift_s) begin
          shreg_r  <= word_s;
          bitcnt_r <= cnt_base_s + 5'd1;
        end else begin
          bitcnt_r <= cnt_base_s;
        end
        if (done_s && !chan_s) begin
          left_r     <= sext(word_s);
          left_vld_r <= 1'b1;
        end else if (done_s && left_vld_r) begin
          push_r      <= 1'b1;
          push_data_r <= {sext(word_s), left_r};
          left_vld_r  <= 1'b0;
        end
      end
    end
  end

  // FIFO storage (contents are never observable while empty, so not reset)
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data_r;
  end

  // EVB responder FSM, control/status registers, FIFO pointers and irq
  always_ff @(posedge clk) begin
    if (rst) begin
      evb_state_r     <= ST_IDLE;
      evb_cmd_finish  <= 1'b0;
      evb_cmd_rd_data <= 32'd0;
      irq             <= 1'b0;
      en_r            <= 1'b0;
      thr_r           <= 5'd0;
      ovf_r           <= 1'b0;
      udf_r           <= 1'b0;
      frames_r        <= 16'd0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
    end else begin
      case (evb_state_r)
        ST_IDLE: begin
          if (evb_cmd_request) begin
            evb_state_r     <= ST_RESP;
            evb_cmd_finish  <= 1'b1;
            evb_cmd_rd_data <= rd_val_s;
          end else begin
            evb_cmd_finish  <= 1'b0;
            evb_cmd_rd_data <= 32'd0;
          end
        end
        ST_RESP: begin
          evb_state_r     <= ST_IDLE;
          evb_cmd_finish  <= 1'b0;
          evb_cmd_rd_data <= 32'd0;
        end
        default: begin
          evb_state_r     <= ST_IDLE;
          evb_cmd_finish  <= 1'b0;
          evb_cmd_rd_data <= 32'd0;
        end
      endcase
      if (ctrl_wr_s) begin
        en_r  <= evb_cmd_wr_data[0];
        thr_r <= evb_cmd_wr_data[12:8];
      end
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
        frames_r <= 16'd0;
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
        count_r <= count_r + CW'(push_ok_s) - CW'(pop_s);
        if (push_r)    frames_r <= frames_r + 16'd1;
      end
      ovf_r <= (ovf_r & ~(w1c_s & evb_cmd_wr_data[16])) | ovf_set_s;
      udf_r <= (udf_r & ~(w1c_s & evb_cmd_wr_data[17])) | udf_set_s;
      irq   <= en_r & (thr_r != 5'd0) & (8'(count_r) >= 8'(thr_r));
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames bit by bit and checks EVB reads
// against a scoreboard of expected stereo words.
module tb_i2s_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        bclk, lrclk, sdata;
  logic        req0, req1;
  logic [3:0]  addr;
  logic [1:0]  mask;
  logic [31:0] wdata;
  logic        fin0, fin1, irq0, irq1;
  logic [31:0] rd0, rd1;
  logic [31:0] exp_q[$];
  logic        pend;
  bit          tail_sent;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_W(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .io_i2s_bclk(bclk), .io_i2s_lrclk(lrclk), .io_i2s_data(sdata),
    .evb_cmd_request(req0), .evb_cmd_addr(addr), .evb_cmd_wr_mask(mask),
    .evb_cmd_wr_data(wdata), .evb_cmd_finish(fin0), .evb_cmd_rd_data(rd0), .irq(irq0));

  i2s_rx #(.SAMPLE_W(12), .FIFO_DEPTH(16)) dut12 (
    .clk(clk), .rst(rst), .io_i2s_bclk(bclk), .io_i2s_lrclk(lrclk), .io_i2s_data(sdata),
    .evb_cmd_request(req1), .evb_cmd_addr(addr), .evb_cmd_wr_mask(mask),
    .evb_cmd_wr_data(wdata), .evb_cmd_finish(fin1), .evb_cmd_rd_data(rd1), .irq(irq1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called and returns just after a negedge; finish must pulse for exactly one cycle
  task automatic evb(input bit sel, input logic [3:0] a, input logic [1:0] m,
                     input logic [31:0] d, output logic [31:0] rd);
    addr = a; mask = m; wdata = d;
    if (sel) req1 = 1'b1; else req0 = 1'b0 | 1'b1;
    @(posedge clk); #1;
    chk("finish_hi", 32'(sel ? fin1 : fin0), 32'd1);
    rd = sel ? rd1 : rd0;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("finish_lo", 32'(sel ? fin1 : fin0), 32'd0);
    chk("rd_idle", sel ? rd1 : rd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic wr(input bit sel, input logic [3:0] a, input logic [1:0] m, input logic [31:0] d);
    logic [31:0] unused_rd;
    evb(sel, a, m, d, unused_rd);
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    evb(1'b0, a, 2'b00, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] rd, exp;
    evb(1'b0, 4'h2, 2'b00, 32'd0, rd);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk(tag, rd, exp);
  endtask

  task automatic send_bit(input logic ws, input logic d);
    bclk = 1'b0; lrclk = ws; sdata = d;
    repeat (5) @(negedge clk);
    bclk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic db(input logic [15:0] v, input int j, input int w);
    if (j < w) return v[w-1-j];
    else return 1'b0;
  endfunction

  // ws leads data by one bit: a word's LSB goes out in the first bit of the next slot
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int s, input int w);
    for (int ch = 0; ch < 2; ch++) begin
      logic [15:0] v;
      v = (ch == 0) ? l : r;
      if (!(ch == 0 && tail_sent)) send_bit(1'(ch), pend);
      for (int j = 0; j < s - 1; j++) send_bit(1'(ch), db(v, j, w));
      pend = db(v, s - 1, w);
    end
    tail_sent = 1'b0;
  endtask

  task automatic tail();
    send_bit(1'b0, pend);
    pend = 1'b0; tail_sent = 1'b1;
  endtask

  task automatic resync();
    send_bit(1'b1, pend);
    send_bit(1'b1, 1'b0);
    pend = 1'b0; tail_sent = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr = 4'h0; mask = 2'b00; wdata = 32'd0;
    pend = 1'b0; tail_sent = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_irq", 32'(irq0), 32'd0);
    chk("rst_finish", 32'(fin0), 32'd0);
    chk("rst_rd_data", rd0, 32'd0);
    chk_reg("rst_ctrl", 4'h0, 32'h0000_0000);
    chk_reg("rst_status", 4'h1, 32'h0000_0100);
    chk_reg("rst_frames", 4'h3, 32'h0000_0000);

    // Basic frames at 16- and 32-bit slots
    wr(1'b0, 4'h0, 2'b01, 32'h1);
    chk_reg("ctrl_en", 4'h0, 32'h0000_0001);
    resync();
    frame(16'h1234, 16'hABCD, 16, 16); exp_q.push_back(32'hABCD_1234);
    frame(16'h1234, 16'hABCD, 32, 16); exp_q.push_back(32'hABCD_1234);
    tail();
    repeat (10) @(negedge clk);
    chk_reg("frames_2", 4'h3, 32'h0000_0002);
    chk_reg("status_cnt2", 4'h1, 32'h0000_0002);
    pop_chk("data_slot16");
    pop_chk("data_slot32");
    chk_reg("status_empty", 4'h1, 32'h0000_0100);

    // 12-bit samples are sign-extended
    wr(1'b0, 4'h0, 2'b01, 32'h0);
    wr(1'b1, 4'h0, 2'b01, 32'h1);
    resync();
    frame(16'h0800, 16'h07FF, 16, 12);
    tail();
    repeat (10) @(negedge clk);
    evb(1'b1, 4'h2, 2'b00, 32'd0, rd);
    chk("data_w12", rd, 32'h07FF_F800);
    wr(1'b1, 4'h0, 2'b01, 32'h0);

    // Overflow: 17 frames into 16 entries
    wr(1'b0, 4'h0, 2'b01, 32'h1);
    resync();
    for (int i = 0; i < 17; i++) begin
      frame(16'h1000 + 16'(i), 16'h2000 + 16'(i), 16, 16);
      if (i < 16) exp_q.push_back({16'h2000 + 16'(i), 16'h1000 + 16'(i)});
    end
    tail();
    repeat (10) @(negedge clk);
    chk_reg("status_full_ovf", 4'h1, 32'h0001_0210);
    wr(1'b0, 4'h1, 2'b10, 32'h0001_0000);
    chk_reg("status_ovf_w1c", 4'h1, 32'h0000_0210);
    for (int i = 0; i < 16; i++) pop_chk("data_ovf_order");
    chk_reg("status_drained", 4'h1, 32'h0000_0100);

    // Underflow, then threshold irq
    evb(1'b0, 4'h2, 2'b00, 32'd0, rd);
    chk("data_empty", rd, 32'h0);
    chk_reg("status_udf", 4'h1, 32'h0002_0100);
    wr(1'b0, 4'h1, 2'b10, 32'h0002_0000);
    chk_reg("status_udf_w1c", 4'h1, 32'h0000_0100);
    wr(1'b0, 4'h0, 2'b01, 32'h0000_0401);
    for (int i = 0; i < 3; i++) begin
      frame(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16, 16);
      exp_q.push_back({16'h0200 + 16'(i), 16'h0100 + 16'(i)});
    end
    tail();
    repeat (10) @(negedge clk);
    chk("irq_below_thr", 32'(irq0), 32'd0);
    frame(16'h0103, 16'h0203, 16, 16); exp_q.push_back(32'h0203_0103);
    tail();
    repeat (10) @(negedge clk);
    chk("irq_at_thr", 32'(irq0), 32'd1);
    pop_chk("data_irq_pop");
    chk("irq_after_pop", 32'(irq0), 32'd0);
    for (int i = 0; i < 3; i++) pop_chk("data_irq_drain");

    // Disable mid left slot, re-enable mid right slot
    wr(1'b0, 4'h0, 2'b01, 32'h1);
    for (int j = 0; j < 8; j++) send_bit(1'b0, 1'b1);
    wr(1'b0, 4'h0, 2'b01, 32'h0);
    for (int j = 0; j < 8; j++) send_bit(1'b0, 1'b1);
    for (int j = 0; j < 7; j++) send_bit(1'b1, 1'b1);
    wr(1'b0, 4'h0, 2'b01, 32'h1);
    for (int j = 0; j < 9; j++) send_bit(1'b1, 1'(j & 1));
    pend = 1'b0; tail_sent = 1'b0;
    frame(16'h1111, 16'h2222, 16, 16); exp_q.push_back(32'h2222_1111);
    tail();
    repeat (10) @(negedge clk);
    chk_reg("status_reenable", 4'h1, 32'h0000_0001);
    pop_chk("data_reenable");

    // Flush on the same cycle as a push: flush wins
    frame(16'h3333, 16'h4444, 16, 16);
    bclk = 1'b0; lrclk = 1'b0; sdata = pend;
    repeat (5) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(negedge clk);
    evb(1'b0, 4'h0, 2'b01, 32'h3, rd);
    pend = 1'b0; tail_sent = 1'b1;
    repeat (10) @(negedge clk);
    chk_reg("status_flush_push", 4'h1, 32'h0000_0100);
    chk_reg("frames_flush", 4'h3, 32'h0000_0000);
    chk_reg("ctrl_flush_reads0", 4'h0, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
